// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the execute stage (port 0) and the
// branch/address unit (port 1). Define ALU_ARB_RR_EN for round-robin tie-breaking; the default is fixed priority to port 0.
module alu_arbiter #(
  parameter int W   = 32,
  parameter int SHW = 5,
  parameter int CW  = 4,
  parameter int FW  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           p0_valid,
  output logic           p0_ready,
  input  logic [W-1:0]   p0_in1,
  input  logic [W-1:0]   p0_in2,
  input  logic [SHW-1:0] p0_shamt,
  input  logic [CW-1:0]  p0_control,
  output logic           p0_resp_valid,
  input  logic           p0_resp_ready,
  output logic [W-1:0]   p0_out,
  output logic [FW-1:0]  p0_flag,
  input  logic           p1_valid,
  output logic           p1_ready,
  input  logic [W-1:0]   p1_in1,
  input  logic [W-1:0]   p1_in2,
  input  logic [SHW-1:0] p1_shamt,
  input  logic [CW-1:0]  p1_control,
  output logic           p1_resp_valid,
  input  logic           p1_resp_ready,
  output logic [W-1:0]   p1_out,
  output logic [FW-1:0]  p1_flag,
  output logic [W-1:0]   alu_in1,
  output logic [W-1:0]   alu_in2,
  output logic [SHW-1:0] alu_shamt,
  output logic [CW-1:0]  alu_control,
  input  logic [W-1:0]   alu_out,
  input  logic [FW-1:0]  alu_flag
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;
  logic [W-1:0]   in1_q, in1_d;
  logic [W-1:0]   in2_q, in2_d;
  logic [SHW-1:0] shamt_q, shamt_d;
  logic [CW-1:0]  ctl_q, ctl_d;
  logic [W-1:0]   out_q, out_d;
  logic [FW-1:0]  flag_q, flag_d;
  logic           gnt0, gnt1;

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;

  // On a tie, the port that did not win last time is granted.
  always_comb begin
    gnt0 = p0_valid & (~p1_valid | last_q);
    gnt1 = p1_valid & (~p0_valid | ~last_q);
  end
`else
  always_comb begin
    gnt0 = p0_valid;
    gnt1 = p1_valid & ~p0_valid;
  end
`endif

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    in1_d         = in1_q;
    in2_d         = in2_q;
    shamt_d       = shamt_q;
    ctl_d         = ctl_q;
    out_d         = out_q;
    flag_d        = flag_q;
`ifdef ALU_ARB_RR_EN
    last_d        = last_q;
`endif
    p0_ready      = 1'b0;
    p1_ready      = 1'b0;
    p0_resp_valid = 1'b0;
    p1_resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        p0_ready = gnt0;
        p1_ready = gnt1;
        if (gnt0 | gnt1) begin
          state_d = EXEC;
          owner_d = gnt1;
          in1_d   = gnt1 ? p1_in1     : p0_in1;
          in2_d   = gnt1 ? p1_in2     : p0_in2;
          shamt_d = gnt1 ? p1_shamt   : p0_shamt;
          ctl_d   = gnt1 ? p1_control : p0_control;
`ifdef ALU_ARB_RR_EN
          last_d  = gnt1;
`endif
        end
      end
      EXEC: begin
        out_d   = alu_out;
        flag_d  = alu_flag;
        state_d = RESP;
      end
      RESP: begin
        p0_resp_valid = ~owner_q;
        p1_resp_valid = owner_q;
        if (owner_q ? p1_resp_ready : p0_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      shamt_q <= '0;
      ctl_q   <= '0;
      out_q   <= '0;
      flag_q  <= '0;
`ifdef ALU_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      shamt_q <= shamt_d;
      ctl_q   <= ctl_d;
      out_q   <= out_d;
      flag_q  <= flag_d;
`ifdef ALU_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // The ALU is driven straight from the operand registers in every state.
  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;
  assign alu_shamt   = shamt_q;
  assign alu_control = ctl_q;
  assign p0_out      = out_q;
  assign p1_out      = out_q;
  assign p0_flag     = flag_q;
  assign p1_flag     = flag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives both ports of alu_arbiter against an ALU stub and checks it with a
// per-cycle timing/arbitration reference model, a table of directed vectors and random traffic.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid [2];
  logic        resp_ready [2];
  logic [31:0] in1 [2];
  logic [31:0] in2 [2];
  logic [4:0]  shamt [2];
  logic [3:0]  ctl [2];

  logic        p0_ready, p1_ready, p0_resp_valid, p1_resp_valid;
  logic [31:0] p0_out, p1_out, alu_in1, alu_in2, alu_out;
  logic [2:0]  p0_flag, p1_flag, alu_flag;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_control;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_valid(valid[0]), .p0_ready(p0_ready), .p0_in1(in1[0]), .p0_in2(in2[0]),
    .p0_shamt(shamt[0]), .p0_control(ctl[0]), .p0_resp_valid(p0_resp_valid),
    .p0_resp_ready(resp_ready[0]), .p0_out(p0_out), .p0_flag(p0_flag),
    .p1_valid(valid[1]), .p1_ready(p1_ready), .p1_in1(in1[1]), .p1_in2(in2[1]),
    .p1_shamt(shamt[1]), .p1_control(ctl[1]), .p1_resp_valid(p1_resp_valid),
    .p1_resp_ready(resp_ready[1]), .p1_out(p1_out), .p1_flag(p1_flag),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt), .alu_control(alu_control),
    .alu_out(alu_out), .alu_flag(alu_flag)
  );

  // ALU stub: returns {carry, negative, zero, out}
  function automatic logic [34:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [4:0] s, logic [3:0] c);
    logic [32:0] r;
    case (c)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {1'b0, a} + {1'b0, ~b} + 33'd1;
      4'd2:    r = {1'b0, a & b};
      4'd3:    r = {1'b0, a | b};
      4'd4:    r = {1'b0, a ^ b};
      4'd5:    r = {1'b0, a << s};
      4'd6:    r = {1'b0, a >> s};
      default: r = {1'b0, a};
    endcase
    return {r[32], r[31], (r[31:0] == 32'd0), r[31:0]};
  endfunction

  assign {alu_flag, alu_out} = alu_fn(alu_in1, alu_in2, alu_shamt, alu_control);

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one outstanding operation, described by its accept cycle and owner.
  int          cyc = 0;
  bit          busy = 0;
  int          acc = 0;
  int          own = 0;
  int          last = 1;
  int          done_cnt = 0;
  logic [31:0] eo, obs_out;
  logic [2:0]  ef, obs_flag;
  logic [72:0] exp_ops;
  int          obs_order[$];

  function automatic int pick(logic v0, logic v1, int lst);
    if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
      return (lst == 0) ? 1 : 0;
`else
      return (lst < 0) ? 1 : 0;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic cycle();
    int g;
    int accepted;
    logic [1:0] exp_rdy, exp_rv;
    g = -1;
    accepted = -1;
    exp_rdy = 2'b00;
    exp_rv = 2'b00;
    @(negedge clk);
    cyc++;
    if (!busy) begin
      g = pick(valid[0], valid[1], last);
      if (g >= 0) exp_rdy[g] = 1'b1;
    end else if (cyc >= acc + 2) begin
      exp_rv[own] = 1'b1;
    end
    chk("ready", 80'({p1_ready, p0_ready}), 80'(exp_rdy));
    chk("resp_valid", 80'({p1_resp_valid, p0_resp_valid}), 80'(exp_rv));
    if (busy && cyc > acc)
      chk("alu_operands", 80'({alu_in1, alu_in2, alu_shamt, alu_control}), 80'(exp_ops));
    if (exp_rv != 2'b00) begin
      chk("resp_out", 80'(own == 1 ? p1_out : p0_out), 80'(eo));
      chk("resp_flag", 80'(own == 1 ? p1_flag : p0_flag), 80'(ef));
    end
    if (!rst && valid[0] && p0_ready) obs_order.push_back(0);
    if (!rst && valid[1] && p1_ready) obs_order.push_back(1);
    if (rst) begin
      busy = 0;
      last = 1;
    end else if (!busy) begin
      if (g >= 0) begin
        busy = 1;
        acc = cyc;
        own = g;
        exp_ops = {in1[g], in2[g], shamt[g], ctl[g]};
        {ef, eo} = alu_fn(in1[g], in2[g], shamt[g], ctl[g]);
        last = g;
        accepted = g;
      end
    end else if (exp_rv != 2'b00 && resp_ready[own]) begin
      busy = 0;
      done_cnt++;
      obs_out = (own == 1) ? p1_out : p0_out;
      obs_flag = (own == 1) ? p1_flag : p0_flag;
    end
    @(posedge clk);
    #1;
    // Inputs are only sampled on accept, so scramble them once taken.
    if (accepted >= 0) begin
      valid[accepted] = 1'b0;
      in1[accepted] = $urandom;
      in2[accepted] = $urandom;
      shamt[accepted] = 5'($urandom);
      ctl[accepted] = 4'($urandom);
    end
  endtask

  task automatic set_req(int p, logic [31:0] a, logic [31:0] b, logic [4:0] s, logic [3:0] c);
    valid[p] = 1'b1;
    in1[p] = a;
    in2[p] = b;
    shamt[p] = s;
    ctl[p] = c;
  endtask

  task automatic wait_done(int target, int budget, string name);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    chk(name, 80'(done_cnt), 80'(target));
  endtask

  task automatic wait_accept(int budget, string name);
    int n;
    n = 0;
    while (!busy && n < budget) begin
      cycle();
      n++;
    end
    chk(name, 80'(busy), 80'(1));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    valid[0] = 1'b0;
    valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    busy = 0;
    last = 1;
  endtask

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  s;
    logic [3:0]  c;
    logic [31:0] exp_out;
    logic [2:0]  exp_flag;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int n;
    int rem[2];
    vecs[0] = '{0, 32'd0,          32'd5,          5'd0,  4'd0, 32'd5,          3'b000};
    vecs[1] = '{1, 32'd105,        32'd106,        5'd0,  4'd0, 32'd211,        3'b000};
    vecs[2] = '{0, 32'hFFFF_FFFF,  32'd1,          5'd0,  4'd0, 32'd0,          3'b101};
    vecs[3] = '{1, 32'h0000_F0F0,  32'h0000_0FF0,  5'd0,  4'd2, 32'h0000_00F0,  3'b000};
    vecs[4] = '{0, 32'd1,          32'd0,          5'd31, 4'd5, 32'h8000_0000,  3'b010};
    vecs[5] = '{1, 32'd3,          32'd5,          5'd0,  4'd1, 32'hFFFF_FFFE,  3'b010};
    vecs[6] = '{0, 32'h8000_0000,  32'd0,          5'd4,  4'd6, 32'h0800_0000,  3'b000};
    vecs[7] = '{1, 32'h8000_0000,  32'h8000_0000,  5'd0,  4'd0, 32'd0,          3'b101};

    for (int p = 0; p < 2; p++) begin
      valid[p] = 1'b0;
      resp_ready[p] = 1'b0;
      in1[p] = '0;
      in2[p] = '0;
      shamt[p] = '0;
      ctl[p] = '0;
    end

    // Reset state
    reset_dut();
    chk("rst_ready", 80'({p1_ready, p0_ready}), 80'(0));
    chk("rst_resp_valid", 80'({p1_resp_valid, p0_resp_valid}), 80'(0));
    chk("rst_alu_in1", 80'(alu_in1), 80'(0));
    chk("rst_out", 80'(p0_out), 80'(0));
    cycle();

    // Directed vectors, one port at a time
    for (int i = 0; i < 8; i++) begin
      d = done_cnt;
      set_req(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);
      resp_ready[vecs[i].port] = 1'b1;
      wait_done(d + 1, 12, "tbl_done");
      chk("tbl_out", 80'(obs_out), 80'(vecs[i].exp_out));
      chk("tbl_flag", 80'(obs_flag), 80'(vecs[i].exp_flag));
      resp_ready[vecs[i].port] = 1'b0;
    end

    // Both ports contending, 4 ops each
    reset_dut();
    obs_order.delete();
    rem[0] = 4;
    rem[1] = 4;
    resp_ready[0] = 1'b1;
    resp_ready[1] = 1'b1;
    d = done_cnt;
    n = 0;
    while (done_cnt < d + 8 && n < 60) begin
      for (int p = 0; p < 2; p++)
        if (!valid[p] && rem[p] > 0) begin
          set_req(p, $urandom, $urandom, 5'($urandom), 4'($urandom_range(0, 7)));
          rem[p]--;
        end
      cycle();
      n++;
    end
    chk("contend_done", 80'(done_cnt), 80'(d + 8));
    chk("contend_count", 80'(obs_order.size()), 80'(8));
    if (obs_order.size() == 8)
      for (int i = 0; i < 8; i++) begin
`ifdef ALU_ARB_RR_EN
        chk("grant_order", 80'(obs_order[i]), 80'(i % 2));
`else
        chk("grant_order", 80'(obs_order[i]), 80'(i < 4 ? 0 : 1));
`endif
      end

    // Response held while the owner stalls; other port waits
    resp_ready[0] = 1'b1;
    resp_ready[1] = 1'b0;
    d = done_cnt;
    set_req(1, 32'd105, 32'd106, 5'd0, 4'd0);
    wait_accept(10, "stall_accept");
    set_req(0, 32'd7, 32'd8, 5'd0, 4'd0);
    for (int i = 0; i < 7; i++) cycle();
    chk("stall_out", 80'(p1_out), 80'(211));
    chk("stall_p0_ready", 80'(p0_ready), 80'(0));
    chk("stall_resp_valid", 80'(p1_resp_valid), 80'(1));
    resp_ready[1] = 1'b1;
    wait_done(d + 1, 5, "stall_done");
    chk("stall_final_out", 80'(obs_out), 80'(211));
    wait_done(d + 2, 10, "after_stall_done");
    chk("after_stall_out", 80'(obs_out), 80'(15));

    // Reset during EXEC drops the op
    d = done_cnt;
    set_req(0, 32'd1, 32'd2, 5'd0, 4'd0);
    wait_accept(10, "abort_accept");
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("abort_no_resp", 80'({p1_resp_valid, p0_resp_valid}), 80'(0));
    chk("abort_done", 80'(done_cnt), 80'(d));
    set_req(1, 32'd9, 32'd10, 5'd0, 4'd0);
    resp_ready[1] = 1'b1;
    wait_done(d + 1, 10, "post_abort_done");
    chk("post_abort_out", 80'(obs_out), 80'(19));

    // resp_ready on the non-owner is ignored
    d = done_cnt;
    resp_ready[0] = 1'b0;
    resp_ready[1] = 1'b0;
    set_req(1, 32'd20, 32'd22, 5'd0, 4'd0);
    wait_accept(10, "ignore_accept");
    cycle();
    cycle();
    resp_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("ignore_resp_valid", 80'(p1_resp_valid), 80'(1));
    chk("ignore_done", 80'(done_cnt), 80'(d));
    resp_ready[0] = 1'b0;
    resp_ready[1] = 1'b1;
    wait_done(d + 1, 5, "ignore_final_done");
    chk("ignore_out", 80'(obs_out), 80'(42));

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!valid[p] && $urandom_range(0, 2) == 0)
          set_req(p, $urandom, $urandom, 5'($urandom), 4'($urandom_range(0, 7)));
        resp_ready[p] = ($urandom_range(0, 2) != 0);
      end
      cycle();
    end
    resp_ready[0] = 1'b1;
    resp_ready[1] = 1'b1;
    n = 0;
    while ((busy || valid[0] || valid[1]) && n < 30) begin
      cycle();
      n++;
    end
    chk("drain_idle", 80'({busy, valid[0], valid[1]}), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
